// File: rtl/fu_div_sched.sv
// fu_div_sched: round-robin arbiter sharing one multi-cycle divider across NUM_REQ issue ports
module fu_div_sched #(
   parameter int NUM_REQ   = 2,
   parameter int TAG_W     = 4,
   parameter int FLUSH_CYC = 40
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [32*NUM_REQ-1:0]      req_a,
   input  logic [32*NUM_REQ-1:0]      req_b,
   input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
   output logic                       div_en,
   output logic [31:0]                div_a,
   output logic [31:0]                div_b,
   input  logic                       div_finish,
   input  logic [31:0]                div_res,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_data,
   output logic [TAG_W-1:0]           rsp_tag,
   output logic [$clog2(NUM_REQ)-1:0] rsp_src,
   output logic                       rsp_dbz,
   output logic                       busy
);
   localparam int SW = $clog2(NUM_REQ);
   localparam int CW = $clog2(FLUSH_CYC + 1);
   typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [SW-1:0] rr_ptr, gnt, src_q;
   logic found, take;
   logic [31:0] sel_a, sel_b, a_q, b_q, data_q;
   logic [TAG_W-1:0] sel_tag, tag_q;
   logic dbz_q;
   // first valid port at or after rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      gnt = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[SW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
            found = 1'b1;
            gnt = SW'((int'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end
   assign take      = (state == IDLE) && found;
   assign sel_a     = req_a[int'(gnt)*32 +: 32];
   assign sel_b     = req_b[int'(gnt)*32 +: 32];
   assign sel_tag   = req_tag[int'(gnt)*TAG_W +: TAG_W];
   assign req_ready = take ? NUM_REQ'(1) << gnt : '0;
   assign div_en    = state == ISSUE;
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign rsp_valid = state == DONE;
   assign rsp_data  = data_q;
   assign rsp_tag   = tag_q;
   assign rsp_src   = src_q;
   assign rsp_dbz   = dbz_q;
   assign busy      = state != IDLE;
   // state register; reset lands in FLUSH because the divider itself is never reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FLUSH;
      else        state <= state_nx;
   end
   // next state; divide-by-zero skips the divider, stray finishes outside WAIT are ignored
   always_comb begin
      state_nx = state;
      case (state)
         FLUSH:   state_nx = (cnt == '0) ? IDLE : FLUSH;
         IDLE:    state_nx = take ? ((sel_b == '0) ? DONE : ISSUE) : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = div_finish ? DONE : WAIT;
         DONE:    state_nx = rsp_ready ? IDLE : DONE;
         default: state_nx = FLUSH;
      endcase
   end
   // operand/response latches, flush counter and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= CW'(FLUSH_CYC);
         rr_ptr <= '0;
         a_q    <= '0;
         b_q    <= '0;
         data_q <= '0;
         tag_q  <= '0;
         src_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         if (state == FLUSH && cnt != '0) cnt <= cnt - CW'(1);
         if (take) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            tag_q  <= sel_tag;
            src_q  <= gnt;
            dbz_q  <= sel_b == '0;
            if (sel_b == '0) data_q <= '1;
         end
         if (state == WAIT && div_finish) data_q <= div_res;
         if (state == DONE && rsp_ready)
            rr_ptr <= (src_q == SW'(NUM_REQ - 1)) ? '0 : src_q + SW'(1);
      end
   end
endmodule

// File: tb/tb_fu_div_sched.sv
// tb_fu_div_sched: directed, table-driven and randomized checks of the divider scheduler
module tb_fu_div_sched;
   localparam int N = 2, TW = 4, FC = 40;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [32*N-1:0] req_a = '0, req_b = '0;
   logic [TW*N-1:0] req_tag = '0;
   logic div_en, div_finish, rsp_valid, rsp_dbz, busy;
   logic rsp_ready = 1'b0;
   logic [31:0] div_a, div_b, div_res, rsp_data;
   logic [TW-1:0] rsp_tag;
   logic [0:0] rsp_src;
   int checks = 0, errors = 0;

   typedef struct {int port; logic [31:0] a; logic [31:0] b; logic [3:0] tag; logic [31:0] exp_data; logic exp_dbz;} vec_t;
   typedef struct {logic [31:0] data; logic [3:0] tag; logic [0:0] src; logic dbz;} rsp_t;
   vec_t tbl[6];
   rsp_t sb[$];
   int model_rr = 0;
   bit outstanding = 0;

   always #5 clk = ~clk;

   fu_div_sched #(.NUM_REQ(N), .TAG_W(TW), .FLUSH_CYC(FC)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .div_en(div_en),
      .div_a(div_a), .div_b(div_b), .div_finish(div_finish), .div_res(div_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_dbz(rsp_dbz), .busy(busy));

   // divider model: no reset, finishes lat_next cycles after the start pulse
   int lat_cnt = 0, lat_next = 3, en_count = 0;
   logic [31:0] la = '0, lb = 32'd1;
   logic fin_force = 1'b0;
   always @(posedge clk) begin
      if (div_en) begin
         lat_cnt <= lat_next;
         la <= div_a;
         lb <= div_b;
         en_count <= en_count + 1;
      end else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
   end
   assign div_finish = (lat_cnt == 1) | fin_force;
   assign div_res = (lb == '0) ? 32'hFFFFFFFF : la / lb;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [38:0] rsp_vec();
      return {rsp_valid, rsp_data, rsp_tag, rsp_src, rsp_dbz};
   endfunction

   task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, output bit ok);
      ok = 0;
      req_valid = '0;
      req_valid[p] = 1'b1;
      req_a[p*32 +: 32] = a;
      req_b[p*32 +: 32] = b;
      req_tag[p*TW +: TW] = t;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready[p]) begin
            ok = 1;
            break;
         end
         tick();
      end
      tick();
      req_valid = '0;
   endtask

   task automatic wait_rsp(output bit ok, output logic [38:0] got);
      ok = 0;
      got = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            got = rsp_vec();
            break;
         end
         tick();
      end
   endtask

   task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, output logic [38:0] got);
      bit ok;
      issue(p, a, b, t, ok);
      chk("op_accept", 64'(ok), 64'(1));
      wait_rsp(ok, got);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // per-cycle reference: fixed rr order, one request outstanding, in-order answers
   task automatic mon();
      logic [N-1:0] er;
      int gp;
      rsp_t e;
      er = '0;
      gp = 0;
      @(negedge clk);
      if (!outstanding)
         for (int i = 0; i < N; i++) begin
            int k;
            k = (model_rr + i) % N;
            if (er == '0 && req_valid[k]) begin
               er[k] = 1'b1;
               gp = k;
            end
         end
      chk("rnd_ready", 64'(req_ready), 64'(er));
      if (er != '0) begin
         e.data = (req_b[gp*32 +: 32] == '0) ? 32'hFFFFFFFF : req_a[gp*32 +: 32] / req_b[gp*32 +: 32];
         e.tag = req_tag[gp*TW +: TW];
         e.src = 1'(gp);
         e.dbz = req_b[gp*32 +: 32] == '0;
         sb.push_back(e);
         outstanding = 1;
      end else if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("rnd_spurious_rsp", 64'(1), 64'(0));
         else begin
            e = sb.pop_front();
            chk("rnd_rsp", 64'(rsp_vec()), 64'({1'b1, e.data, e.tag, e.src, e.dbz}));
            model_rr = (int'(e.src) + 1) % N;
         end
         outstanding = 0;
      end
      tick();
   endtask

   initial begin
      bit ok, seen;
      int e0;
      int g[$];
      logic [38:0] got;
      tbl[0] = '{0, 32'd1000, 32'd10, 4'd1, 32'd100, 1'b0};
      tbl[1] = '{1, 32'd0, 32'd5, 4'd2, 32'd0, 1'b0};
      tbl[2] = '{0, 32'hFFFFFFFF, 32'd1, 4'd3, 32'hFFFFFFFF, 1'b0};
      tbl[3] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'd1, 1'b0};
      tbl[4] = '{0, 32'd5, 32'd7, 4'd15, 32'd0, 1'b0};
      tbl[5] = '{1, 32'd12345, 32'd0, 4'd0, 32'hFFFFFFFF, 1'b1};

      // reset state and flush window
      #1 rst_n = 1'b0;
      req_valid = '1;
      req_b = {32'd3, 32'd3};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({req_ready, rsp_valid, div_en, div_a, rsp_tag, rsp_src, rsp_dbz}), 64'(0));
      chk("reset_data", 64'(rsp_data), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < FC; k++) begin
         fin_force = (k == 3);
         @(negedge clk);
         chk("flush_ready", 64'(req_ready), 64'(0));
         chk("flush_rsp", 64'(rsp_valid), 64'(0));
         tick();
      end
      fin_force = 1'b0;
      req_valid = '0;
      tick();
      tick();
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      tick();

      // single op, exact latency
      lat_next = 3;
      e0 = en_count;
      req_valid = 2'b01;
      req_a[31:0] = 32'd100;
      req_b[31:0] = 32'd7;
      req_tag[3:0] = 4'd5;
      @(negedge clk);
      chk("op_ready", 64'(req_ready), 64'(2'b01));
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("op_en", 64'(div_en), 64'(1));
      chk("op_operands", {div_a, div_b}, {32'd100, 32'd7});
      tick();
      @(negedge clk);
      chk("op_en_pulse", 64'({div_en, rsp_valid, busy}), 64'(3'b001));
      tick();
      @(negedge clk);
      chk("op_wait", 64'(rsp_valid), 64'(0));
      tick();
      @(negedge clk);
      chk("op_finish_cycle", 64'({div_finish, rsp_valid}), 64'(2'b10));
      tick();
      @(negedge clk);
      chk("op_rsp", 64'(rsp_vec()), 64'({1'b1, 32'd14, 4'd5, 1'b0, 1'b0}));
      chk("op_en_count", 64'(en_count - e0), 64'(1));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("op_rsp_gone", 64'(rsp_valid), 64'(0));
      tick();

      // divide-by-zero bypasses the divider
      e0 = en_count;
      req_valid = 2'b10;
      req_a[63:32] = 32'd9;
      req_b[63:32] = 32'd0;
      req_tag[7:4] = 4'd2;
      @(negedge clk);
      chk("dbz_ready", 64'(req_ready), 64'(2'b10));
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("dbz_rsp", 64'(rsp_vec()), 64'({1'b1, 32'hFFFFFFFF, 4'd2, 1'b1, 1'b1}));
      chk("dbz_no_en", 64'(div_en), 64'(0));
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("dbz_en_count", 64'(en_count - e0), 64'(0));
      tick();

      // table of boundary operands
      foreach (tbl[i]) begin
         lat_next = 1 + i;
         run_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].tag, got);
         chk($sformatf("tbl%0d", i), 64'(got), 64'({1'b1, tbl[i].exp_data, tbl[i].tag, 1'(tbl[i].port), tbl[i].exp_dbz}));
      end

      // fairness with both ports always requesting
      lat_next = 2;
      req_valid = 2'b11;
      req_a = {32'd60, 32'd50};
      req_b = {32'd6, 32'd5};
      rsp_ready = 1'b1;
      for (int c = 0; c < 200 && g.size() < 4; c++) begin
         @(negedge clk);
         chk("fair_onehot", 64'($countones(req_ready) <= 1), 64'(1));
         if (req_ready != '0) g.push_back(req_ready[1] ? 1 : 0);
         tick();
      end
      req_valid = '0;
      chk("fair_count", 64'(g.size()), 64'(4));
      for (int i = 0; i < 4; i++) chk("fair_grant", 64'(i < g.size() ? g[i] : -1), 64'(i % 2));
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
         tick();
      end
      tick();
      rsp_ready = 1'b0;

      // backpressure holds the response and blocks new work
      lat_next = 3;
      issue(0, 32'd50, 32'd5, 4'd3, ok);
      chk("bp_accept", 64'(ok), 64'(1));
      wait_rsp(ok, got);
      tick();
      req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_stable", 64'(rsp_vec()), 64'({1'b1, 32'd10, 4'd3, 1'b0, 1'b0}));
         chk("bp_blocked", 64'({req_ready, div_en}), 64'(0));
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // reset during WAIT; orphaned finish must be discarded
      lat_next = 3;
      issue(1, 32'd1000, 32'd10, 4'd7, ok);
      chk("rst_accept", 64'(ok), 64'(1));
      tick();
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_mid_outputs", 64'({rsp_valid, div_en, req_ready, div_a}), 64'(0));
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < FC + 5; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
         tick();
      end
      chk("rst_orphan_dropped", 64'(seen), 64'(0));
      run_op(0, 32'd77, 32'd7, 4'd9, got);
      chk("rst_next_op", 64'(got), 64'({1'b1, 32'd11, 4'd9, 1'b0, 1'b0}));

      // randomized traffic against the reference
      model_rr = 0;
      outstanding = 0;
      for (int c = 0; c < 800; c++) begin
         req_valid = N'($urandom);
         for (int p = 0; p < N; p++) begin
            req_a[p*32 +: 32] = $urandom;
            req_b[p*32 +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            req_tag[p*TW +: TW] = TW'($urandom);
         end
         rsp_ready = $urandom_range(0, 3) != 0;
         lat_next = $urandom_range(1, 6);
         mon();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 100 && (sb.size() != 0 || outstanding); c++) mon();
      chk("rnd_drain", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
